// File: rtl/cc_poscomparator_pkg.sv
// rtl/cc_poscomparator_pkg.sv - shared types and constants for the position comparator scan
package cc_poscomparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scanStateT;

  localparam int MODE_OVERLAP = 0;
  localparam int MODE_EXACT   = 1;

  localparam int                  HITCNT_W   = 4;
  localparam logic [HITCNT_W-1:0] HITCNT_MAX = 4'd15;

  function automatic logic [HITCNT_W-1:0] satInc(input logic [HITCNT_W-1:0] cnt);
    return (cnt == HITCNT_MAX) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/cc_poscomparator_scan_if.sv
// rtl/cc_poscomparator_scan_if.sv - frame request, matrix row and result signals of the scan block
interface cc_poscomparator_scan_if
  import cc_poscomparator_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int ROWS      = 8,
  parameter int PLAYERS   = 2
);
  localparam int RW = $clog2(ROWS);

  logic                          CC_POSCOMPARATOR_SCAN_start;
  logic                          CC_POSCOMPARATOR_SCAN_clear;
  logic [DATAWIDTH-1:0]          CC_POSCOMPARATOR_SCAN_row_data;
  logic [PLAYERS*DATAWIDTH-1:0]  CC_POSCOMPARATOR_SCAN_pos;
  logic [PLAYERS*RW-1:0]         CC_POSCOMPARATOR_SCAN_prow;
  logic [RW-1:0]                 CC_POSCOMPARATOR_SCAN_row_idx;
  logic                          CC_POSCOMPARATOR_SCAN_busy;
  logic                          CC_POSCOMPARATOR_SCAN_done;
  logic [PLAYERS-1:0]            CC_POSCOMPARATOR_SCAN_hit;
  logic [PLAYERS*HITCNT_W-1:0]   CC_POSCOMPARATOR_SCAN_hitcount;

  modport master (
    output CC_POSCOMPARATOR_SCAN_start, CC_POSCOMPARATOR_SCAN_clear,
           CC_POSCOMPARATOR_SCAN_row_data, CC_POSCOMPARATOR_SCAN_pos,
           CC_POSCOMPARATOR_SCAN_prow,
    input  CC_POSCOMPARATOR_SCAN_row_idx, CC_POSCOMPARATOR_SCAN_busy,
           CC_POSCOMPARATOR_SCAN_done, CC_POSCOMPARATOR_SCAN_hit,
           CC_POSCOMPARATOR_SCAN_hitcount
  );

  modport slave (
    input  CC_POSCOMPARATOR_SCAN_start, CC_POSCOMPARATOR_SCAN_clear,
           CC_POSCOMPARATOR_SCAN_row_data, CC_POSCOMPARATOR_SCAN_pos,
           CC_POSCOMPARATOR_SCAN_prow,
    output CC_POSCOMPARATOR_SCAN_row_idx, CC_POSCOMPARATOR_SCAN_busy,
           CC_POSCOMPARATOR_SCAN_done, CC_POSCOMPARATOR_SCAN_hit,
           CC_POSCOMPARATOR_SCAN_hitcount
  );

endinterface

// File: rtl/cc_poscomparator_cell.sv
// rtl/cc_poscomparator_cell.sv - one player's snapshot, row compare, frame accumulator and hit counter
module cc_poscomparator_cell
  import cc_poscomparator_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int ROWS      = 8,
  parameter int MODE      = MODE_OVERLAP
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     load,
  input  logic                     scanEn,
  input  logic                     doneEn,
  input  logic                     clear,
  input  logic [$clog2(ROWS)-1:0]  rowIdx,
  input  logic [DATAWIDTH-1:0]     rowData,
  input  logic [DATAWIDTH-1:0]     pos,
  input  logic [$clog2(ROWS)-1:0]  prow,
  output logic                     hit,
  output logic [HITCNT_W-1:0]      hitCount
);

  logic [DATAWIDTH-1:0]    posSnap;
  logic [$clog2(ROWS)-1:0] prowSnap;
  logic                    acc;
  logic                    rowMatch;

  // Exact mode treats an all-zero mask as a position too, so an empty row matches it.
  always_comb begin
    rowMatch = 1'b0;
    if (MODE == MODE_EXACT) rowMatch = (rowData == posSnap);
    else                    rowMatch = |(rowData & posSnap);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      posSnap  <= '0;
      prowSnap <= '0;
      acc      <= 1'b0;
      hit      <= 1'b0;
      hitCount <= '0;
    end else begin
      if (load) begin
        posSnap  <= pos;
        prowSnap <= prow;
        acc      <= 1'b0;
      end else if (scanEn && (prowSnap == rowIdx) && rowMatch) begin
        acc <= 1'b1;
      end
      if (doneEn) hit <= acc;
      if (clear)              hitCount <= '0;
      else if (doneEn && acc) hitCount <= satInc(hitCount);
    end
  end

endmodule

// File: rtl/cc_poscomparator_scan.sv
// rtl/cc_poscomparator_scan.sv - frame scan FSM and row counter driving one compare cell per player
module cc_poscomparator_scan
  import cc_poscomparator_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int ROWS      = 8,
  parameter int PLAYERS   = 2,
  parameter int MODE      = MODE_OVERLAP
) (
  input logic                    CC_POSCOMPARATOR_SCAN_CLOCK_50,
  input logic                    CC_POSCOMPARATOR_SCAN_RESET_InLow,
  cc_poscomparator_scan_if.slave bus
);

  localparam int            RW       = $clog2(ROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  scanStateT               state, nextState;
  logic [RW-1:0]           rowIdx, rowIdxNext;
  logic                    load;
  logic [PLAYERS-1:0]      hitVec;
  logic [PLAYERS*HITCNT_W-1:0] hitCountVec;

  always_ff @(posedge CC_POSCOMPARATOR_SCAN_CLOCK_50 or negedge CC_POSCOMPARATOR_SCAN_RESET_InLow) begin
    if (!CC_POSCOMPARATOR_SCAN_RESET_InLow) begin
      state  <= IDLE;
      rowIdx <= '0;
    end else begin
      state  <= nextState;
      rowIdx <= rowIdxNext;
    end
  end

  // Start is only looked at in IDLE, so requests during a frame are dropped.
  always_comb begin
    nextState  = state;
    rowIdxNext = rowIdx;
    load       = 1'b0;
    case (state)
      IDLE: begin
        rowIdxNext = '0;
        if (bus.CC_POSCOMPARATOR_SCAN_start) begin
          load      = 1'b1;
          nextState = SCAN;
        end
      end
      SCAN: begin
        if (rowIdx == LAST_ROW) begin
          rowIdxNext = '0;
          nextState  = DONE;
        end else begin
          rowIdxNext = rowIdx + 1'b1;
        end
      end
      DONE:    nextState = IDLE;
      default: begin
        nextState  = IDLE;
        rowIdxNext = '0;
      end
    endcase
  end

  assign bus.CC_POSCOMPARATOR_SCAN_row_idx  = rowIdx;
  assign bus.CC_POSCOMPARATOR_SCAN_busy     = (state == SCAN) || (state == DONE);
  assign bus.CC_POSCOMPARATOR_SCAN_done     = (state == DONE);
  assign bus.CC_POSCOMPARATOR_SCAN_hit      = hitVec;
  assign bus.CC_POSCOMPARATOR_SCAN_hitcount = hitCountVec;

  for (genvar p = 0; p < PLAYERS; p++) begin : gCell
    cc_poscomparator_cell #(
      .DATAWIDTH (DATAWIDTH),
      .ROWS      (ROWS),
      .MODE      (MODE)
    ) uCell (
      .clk      (CC_POSCOMPARATOR_SCAN_CLOCK_50),
      .rstN     (CC_POSCOMPARATOR_SCAN_RESET_InLow),
      .load     (load),
      .scanEn   (state == SCAN),
      .doneEn   (state == DONE),
      .clear    (bus.CC_POSCOMPARATOR_SCAN_clear),
      .rowIdx   (rowIdx),
      .rowData  (bus.CC_POSCOMPARATOR_SCAN_row_data),
      .pos      (bus.CC_POSCOMPARATOR_SCAN_pos[p*DATAWIDTH +: DATAWIDTH]),
      .prow     (bus.CC_POSCOMPARATOR_SCAN_prow[p*RW +: RW]),
      .hit      (hitVec[p]),
      .hitCount (hitCountVec[p*HITCNT_W +: HITCNT_W])
    );
  end

endmodule
